bcd_7seg_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_7seg_scan_driver.sv | 110 +++++++++++
 tb/tb_bcd_7seg_scan_driver.sv | 134 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and active-low display constants for the two-digit scan driver.
package seg7_pkg;

  typedef enum logic {S_UNITS, S_TENS} slot_t;

  // Segment patterns, active low, bit order g..a.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Anode patterns, active low; an[0]=units, an[1]=tens.
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup; codes 10..15 fall through to the dash pattern.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Two-digit multiplexed common-anode 7-segment driver with registered outputs.
module bcd_7seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int unsigned    CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [3:0]    tens_q, units_q;
  logic [CW-1:0] cnt_q, cnt_d;
  slot_t         slot_q, slot_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_tick_q, frame_tick_d;
  logic          wrap;
  logic [3:0]    digit_sel;
  logic [6:0]    seg_dec;

  assign wrap = (cnt_q == CNT_MAX);

  // Digit latches: overwrite on every load strobe, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q  <= '0;
      units_q <= '0;
    end else if (load) begin
      tens_q  <= bcd_tens;
      units_q <= bcd_units;
    end
  end

  // Refresh counter next value: 0..REFRESH_DIV-1 then wrap.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (wrap) cnt_d = '0;
  end

  // Counter and slot state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= S_UNITS;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  // Slot FSM: toggle between units and tens on each counter wrap.
  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      S_UNITS: if (wrap) slot_d = S_TENS;
      S_TENS:  if (wrap) slot_d = S_UNITS;
      default: slot_d = S_UNITS;
    endcase
  end

  assign digit_sel = (slot_q == S_TENS) ? tens_q : units_q;

  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (seg_dec)
  );

  // Output stage next values from current slot and latched data; tick marks end of tens slot.
  always_comb begin
    an_d         = AN_UNITS;
    seg_d        = seg_dec;
    frame_tick_d = wrap && (slot_q == S_TENS);
    if (slot_q == S_TENS) begin
      if (BLANK_LZ && (tens_q == 4'd0)) begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end else begin
        an_d  = AN_TENS;
      end
    end
  end

  // Registered outputs, blanked during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: two instances (blanking on/off) against a timeline model.
module tb_bcd_7seg_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] bcd_tens = '0;
  logic [3:0] bcd_units = '0;
  logic [6:0] seg_b, seg_n;
  logic [1:0] an_b, an_n;
  logic       ft_b, ft_n;

  int checks = 0;
  int failures = 0;

  // Reference model: latched digits and number of edges since reset released.
  logic [3:0] m_t = '0;
  logic [3:0] m_u = '0;
  int         k = 0;

  logic [6:0] DEC [16];

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .seg(seg_b), .an(an_b), .frame_tick(ft_b)
  );

  bcd_7seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst(rst), .load(load), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .seg(seg_n), .an(an_n), .frame_tick(ft_n)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge, compare to model.
  task automatic step(input logic l, input logic [3:0] t, input logic [3:0] u, input logic r);
    logic [6:0] e_seg_b, e_seg_n;
    logic [1:0] e_an_b, e_an_n;
    logic       e_ft;
    bit         tens_slot;
    @(negedge clk);
    load = l; bcd_tens = t; bcd_units = u; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0; m_t = '0; m_u = '0;
      e_seg_b = 7'h7F; e_an_b = 2'b11;
      e_seg_n = 7'h7F; e_an_n = 2'b11;
      e_ft = 1'b0;
    end else begin
      k++;
      tens_slot = (((k - 1) / DIV) % 2) == 1;
      e_ft = (k % (2 * DIV)) == 0;
      if (tens_slot) begin
        e_an_n = 2'b01; e_seg_n = DEC[m_t];
        if (m_t == 4'd0) begin e_an_b = 2'b11; e_seg_b = 7'h7F; end
        else begin e_an_b = 2'b01; e_seg_b = DEC[m_t]; end
      end else begin
        e_an_n = 2'b10; e_seg_n = DEC[m_u];
        e_an_b = 2'b10; e_seg_b = DEC[m_u];
      end
      if (l) begin m_t = t; m_u = u; end
    end
    chk("seg_blank", seg_b, e_seg_b);
    chk("an_blank", {5'b0, an_b}, {5'b0, e_an_b});
    chk("tick_blank", {6'b0, ft_b}, {6'b0, e_ft});
    chk("seg_noblank", seg_n, e_seg_n);
    chk("an_noblank", {5'b0, an_n}, {5'b0, e_an_n});
    chk("tick_noblank", {6'b0, ft_n}, {6'b0, e_ft});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    DEC = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Reset and idle scan with tens 0.
    step(1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    idle(16);

    // Load 15.
    step(1'b1, 4'd1, 4'd5, 1'b0);
    idle(10);

    // Sweep 0..15 as produced by a binary-to-BCD converter.
    for (int v = 0; v < 16; v++) begin
      step(1'b1, 4'(v / 10), 4'(v % 10), 1'b0);
      idle(8);
    end

    // Non-BCD codes in both digits.
    step(1'b1, 4'hA, 4'hF, 1'b0);
    idle(9);

    // Load on the wrap edge that enters the tens slot.
    while (((k + 1) % (2 * DIV)) != DIV) idle(1);
    step(1'b1, 4'd1, 4'd2, 1'b0);
    idle(6);

    // Reset in the middle of a tens slot.
    step(1'b1, 4'd1, 4'd3, 1'b0);
    while (((k + 1) % (2 * DIV)) != DIV + 2) idle(1);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    idle(10);

    // Reset coinciding with a load: reset wins.
    step(1'b1, 4'd7, 4'd7, 1'b1);
    idle(9);

    // Random loads, codes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
